led_matrix_rx: RTL and testbench
================================

Name: led_matrix_rx

Overview:
- Receive end of the HUB75-style LED panel shift interface: snoops rgb0/rgb1, rgb_clk, rgb_stb, oe_n and the row-address lines, and reconstructs the row data actually latched into the panel.
- Captured rows are held in a 16-row x 32-column x 3-bit image, readable over the 16-bit bus port.
- Used as an on-chip loopback monitor for the panel driver, and as the input stage for a daisy-chained panel controller.

Parameters:
- COLS, 32, columns shifted per row; the column counter is 6 bits.
- ROW_OFFSET, 1, added mod 8 to {rgb_c,rgb_b,rgb_a} at latch to form the stored row. The row lines show the previous row while the new row is latched.
- SYNC_STAGES, 2, synchronizer depth on all panel-side inputs (2..3).
- MIN_BLANK, 8'h20, minimum oe_n-high clk cycles before and after the latch (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rgb_a, rgb_b, rgb_c  in  1 each  row address lines
- rgb0  in  3  {r,g,b}, upper half
- rgb1  in  3  {r,g,b}, lower half
- rgb_clk  in  1  shift clock, rising-edge active
- rgb_stb  in  1  latch strobe, rising-edge active
- oe_n  in  1  output enable, low = lit
- clr  in  1  synchronous clear of counters and error flags
- address  in  10  bus read address
- data_out  out  16  registered read data
- frame_stb  out  1  one-cycle pulse when stored row 7 is latched
- err  out  1  OR of sticky error flags

Behaviour:
- Reset: staging, image, colcnt, frame_count, latch_count and flags all cleared; data_out=0, frame_stb=0, err=0.
- Sampling:
  - All panel inputs pass through SYNC_STAGES flops.
  - Edges are detected on the last synchronized stage against one extra delay flop.
  - Data is sampled from the same stage as the detected edge.
  - Inputs must hold each level at least 1 clk cycle.
- Shift, on rgb_clk rise:
  - If colcnt<COLS: staging0[colcnt]=rgb0, staging1[colcnt]=rgb1, colcnt++.
  - Otherwise: set ovf, discard the data, colcnt holds at COLS.
  - Column index = shift order; the first bit shifted goes to col 0.
- Latch, on rgb_stb rise:
  - row=({c,b,a}+ROW_OFFSET)&7.
  - Copy staging0 to image[0][row] and staging1 to image[1][row].
  - If colcnt<COLS, set unf; still copy, with unshifted columns keeping their previous staging contents.
  - colcnt=0; latch_count++ (16-bit, wraps); last_row=row.
  - If row==7: frame_stb=1 for the next cycle and frame_count++ (16-bit, wraps).
  - Total latency from strobe edge to image update and frame_stb is SYNC_STAGES+1 cycles.
- Simultaneous rgb_clk and rgb_stb rise: shift first, then latch, so the shifted bit is included.
- clr: zeroes frame_count, latch_count and all flags in the same cycle. If an event coincides with clr, clr wins for flags and counters; the image write still occurs.
- Read port (1-cycle latency, registered):
  - address[9]=0: half=address[8], row=address[7:5], col=address[4:0]; data_out={13'b0,r,g,b}.
  - address[9]=1, address[1:0]:
    - 0: {13'b0,blank_err,unf,ovf}
    - 1: frame_count
    - 2: latch_count
    - 3: {7'b0,colcnt[5:0],last_row}
- err=ovf|unf|blank_err, registered.
- Reset mid-row discards partial staging state; the next latch reports unf unless COLS clocks are seen.

Optional Feature:
- Macro LED_MATRIX_RX_BLANK_CHECK_EN.
- When defined:
  - An 8-bit counter counts consecutive oe_n-high cycles, saturating at 8'hFF.
  - At the strobe rise it must be >=MIN_BLANK, else set blank_err.
  - After the strobe, oe_n falling earlier than MIN_BLANK cycles post-strobe also sets blank_err.
- When undefined: no counter is built; blank_err is tied 0 and reads 0.

Test Plan:
- 32 clocks shifting rgb0=3'b100 at col 0 only (else 0), rgb1=3'b011 all columns; lines {c,b,a}=3'd6, strobe -> row 7 written. Reads: addr 0x0E0=0x0004, 0x0E1=0x0000, 0x1E5=0x0003. frame_stb pulses once; frame_count=1.
- Full frame, 8 rows with lines 7,0..6 -> latch_count=8, frame_count=1, every row matches its pattern, err=0.
- 33 rgb_clk pulses then strobe -> ovf=1, status read 0x0001, cols 0..31 hold the first 32 bits.
- 31 pulses then strobe -> unf=1, colcnt read back 0 after the latch, err=1. clr pulse -> status 0, err=0.
- rgb_clk and rgb_stb rise in the same cycle as the 32nd shift -> no unf, col 31 captured.
- With LED_MATRIX_RX_BLANK_CHECK_EN: oe_n high only 0x10 cycles before strobe -> blank_err=1. With exactly 0x20 cycles before and after -> blank_err=0.

Source files
------------

// File: rtl/led_matrix_rx.sv
// led_matrix_rx: HUB75 receive monitor rebuilding latched panel rows into
// a 2-half x 8-row x COLS x 3-bit image, read back over a registered bus.
// Optional oe_n blanking-time check: define LED_MATRIX_RX_BLANK_CHECK_EN.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   rgb_a/b/c         panel row address lines
//   rgb0, rgb1        {r,g,b} for upper / lower half
//   rgb_clk, rgb_stb  shift clock and latch strobe (rising edge)
//   oe_n              output enable, low = lit
//   clr               sync clear of counters and error flags
//   address, data_out bus read port, 1-cycle latency
//   frame_stb         pulse when stored row 7 is latched
//   err               OR of the sticky error flags
module led_matrix_rx #(
   parameter int         COLS        = 32,
   parameter int         ROW_OFFSET  = 1,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] MIN_BLANK   = 8'h20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rgb_a,
   input  logic        rgb_b,
   input  logic        rgb_c,
   input  logic [2:0]  rgb0,
   input  logic [2:0]  rgb1,
   input  logic        rgb_clk,
   input  logic        rgb_stb,
   input  logic        oe_n,
   input  logic        clr,
   input  logic [9:0]  address,
   output logic [15:0] data_out,
   output logic        frame_stb,
   output logic        err
);

   localparam logic [5:0] COLS_W = 6'(COLS);

   // Panel-side synchronizer; bit map of each stage:
   // [11:9] row lines, [8:6] rgb0, [5:3] rgb1,
   // [2] rgb_clk, [1] rgb_stb, [0] oe_n
   logic [11:0] in_w;
   logic [11:0] sync_q [SYNC_STAGES];
   logic [11:0] s_w;
   logic [2:0]  dly_q;

   assign in_w = {rgb_c, rgb_b, rgb_a, rgb0, rgb1,
                  rgb_clk, rgb_stb, oe_n};
   assign s_w  = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         dly_q <= '0;
      end else begin
         sync_q[0] <= in_w;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         dly_q <= s_w[2:0];
      end
   end

   logic [2:0] s_rgb0_w;
   logic [2:0] s_rgb1_w;
   logic [2:0] row_w;
   logic       clk_rise;
   logic       stb_rise;

   assign s_rgb0_w = s_w[8:6];
   assign s_rgb1_w = s_w[5:3];
   assign clk_rise = s_w[2] & ~dly_q[2];
   assign stb_rise = s_w[1] & ~dly_q[1];
   // Row lines still show the previous row during the latch
   assign row_w    = s_w[11:9] + 3'(ROW_OFFSET);

   logic [2:0]  stg0_q [COLS];
   logic [2:0]  stg0_d [COLS];
   logic [2:0]  stg1_q [COLS];
   logic [2:0]  stg1_d [COLS];
   logic [2:0]  img0_q [8][COLS];
   logic [2:0]  img1_q [8][COLS];

   logic [5:0]  colcnt_q, colcnt_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] latch_cnt_q, latch_cnt_d;
   logic [2:0]  last_row_q, last_row_d;
   logic        frame_stb_q, frame_stb_d;
   logic        err_q, err_d;
   logic [15:0] data_out_q, data_out_d;

   logic        blank_w;
   logic        blank_nx;

   always_comb begin
      stg0_d      = stg0_q;
      stg1_d      = stg1_q;
      colcnt_d    = colcnt_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      frame_cnt_d = frame_cnt_q;
      latch_cnt_d = latch_cnt_q;
      last_row_d  = last_row_q;
      frame_stb_d = 1'b0;

      // Shift is resolved before the latch so a coincident
      // strobe sees the bit just shifted in
      if (clk_rise) begin
         if (colcnt_q < COLS_W) begin
            for (int i = 0; i < COLS; i++) begin
               if (colcnt_q == 6'(i)) begin
                  stg0_d[i] = s_rgb0_w;
                  stg1_d[i] = s_rgb1_w;
               end
            end
            colcnt_d = colcnt_q + 6'd1;
         end else begin
            ovf_d = 1'b1;
         end
      end

      if (stb_rise) begin
         if (colcnt_d < COLS_W) begin
            unf_d = 1'b1;
         end
         colcnt_d    = '0;
         latch_cnt_d = latch_cnt_q + 16'd1;
         last_row_d  = row_w;
         if (row_w == 3'd7) begin
            frame_stb_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
      end

      if (clr) begin
         ovf_d       = 1'b0;
         unf_d       = 1'b0;
         frame_cnt_d = '0;
         latch_cnt_d = '0;
      end

      err_d = ovf_d | unf_d | blank_nx;
   end

   always_comb begin
      data_out_d = '0;
      if (!address[9]) begin
         if (address[8]) begin
            data_out_d = {13'b0,
               img1_q[address[7:5]][address[4:0]]};
         end else begin
            data_out_d = {13'b0,
               img0_q[address[7:5]][address[4:0]]};
         end
      end else begin
         unique case (address[1:0])
            2'd0: data_out_d = {13'b0, blank_w, unf_q, ovf_q};
            2'd1: data_out_d = frame_cnt_q;
            2'd2: data_out_d = latch_cnt_q;
            2'd3: data_out_d = {7'b0, colcnt_q, last_row_q};
            default: data_out_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < COLS; c++) begin
            stg0_q[c] <= '0;
            stg1_q[c] <= '0;
         end
         colcnt_q    <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         frame_cnt_q <= '0;
         latch_cnt_q <= '0;
         last_row_q  <= '0;
         frame_stb_q <= 1'b0;
         err_q       <= 1'b0;
         data_out_q  <= '0;
      end else begin
         for (int c = 0; c < COLS; c++) begin
            stg0_q[c] <= stg0_d[c];
            stg1_q[c] <= stg1_d[c];
         end
         colcnt_q    <= colcnt_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         frame_cnt_q <= frame_cnt_d;
         latch_cnt_q <= latch_cnt_d;
         last_row_q  <= last_row_d;
         frame_stb_q <= frame_stb_d;
         err_q       <= err_d;
         data_out_q  <= data_out_d;
      end
   end

   // Image write is not gated by clr
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < COLS; c++) begin
               img0_q[r][c] <= '0;
               img1_q[r][c] <= '0;
            end
         end
      end else if (stb_rise) begin
         for (int c = 0; c < COLS; c++) begin
            img0_q[row_w][c] <= stg0_d[c];
            img1_q[row_w][c] <= stg1_d[c];
         end
      end
   end

`ifdef LED_MATRIX_RX_BLANK_CHECK_EN
   logic [7:0] bcnt_q, bcnt_d;
   logic [7:0] pcnt_q, pcnt_d;
   logic       parm_q, parm_d;
   logic       blank_q, blank_d;
   logic       oe_fall;

   assign oe_fall = dly_q[0] & ~s_w[0];

   always_comb begin
      bcnt_d  = '0;
      pcnt_d  = pcnt_q;
      parm_d  = parm_q;
      blank_d = blank_q;

      if (s_w[0]) begin
         bcnt_d = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;
      end

      // pcnt_q equals cycles elapsed since the strobe edge
      if (parm_q) begin
         if (oe_fall && (pcnt_q < MIN_BLANK)) begin
            blank_d = 1'b1;
         end
         if (pcnt_q >= MIN_BLANK) begin
            parm_d = 1'b0;
         end else begin
            pcnt_d = pcnt_q + 8'd1;
         end
      end

      if (stb_rise) begin
         if (bcnt_q < MIN_BLANK) begin
            blank_d = 1'b1;
         end
         parm_d = 1'b1;
         pcnt_d = 8'd1;
      end

      if (clr) begin
         blank_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q  <= '0;
         pcnt_q  <= '0;
         parm_q  <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         bcnt_q  <= bcnt_d;
         pcnt_q  <= pcnt_d;
         parm_q  <= parm_d;
         blank_q <= blank_d;
      end
   end

   assign blank_w  = blank_q;
   assign blank_nx = blank_d;
`else
   logic unused_blank;
   assign unused_blank = ^{MIN_BLANK, s_w[0], dly_q[0]};
   assign blank_w  = 1'b0;
   assign blank_nx = 1'b0;
`endif

   assign data_out  = data_out_q;
   assign frame_stb = frame_stb_q;
   assign err       = err_q;

endmodule

// File: tb/tb_led_matrix_rx.sv
// tb_led_matrix_rx: directed bench for led_matrix_rx.
// Drives panel inputs on negedges, samples outputs on negedges.
module tb_led_matrix_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rgb_a = 1'b0;
   logic        rgb_b = 1'b0;
   logic        rgb_c = 1'b0;
   logic [2:0]  rgb0 = '0;
   logic [2:0]  rgb1 = '0;
   logic        rgb_clk = 1'b0;
   logic        rgb_stb = 1'b0;
   logic        oe_n = 1'b1;
   logic        clr = 1'b0;
   logic [9:0]  address = '0;
   logic [15:0] data_out;
   logic        frame_stb;
   logic        err;

   led_matrix_rx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rgb_a     (rgb_a),
      .rgb_b     (rgb_b),
      .rgb_c     (rgb_c),
      .rgb0      (rgb0),
      .rgb1      (rgb1),
      .rgb_clk   (rgb_clk),
      .rgb_stb   (rgb_stb),
      .oe_n      (oe_n),
      .clr       (clr),
      .address   (address),
      .data_out  (data_out),
      .frame_stb (frame_stb),
      .err       (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int nstb = 0;
   int stb_cyc = 0;
   int t_raise = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_stb) begin
         nstb++;
         stb_cyc = cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   typedef struct {
      logic [9:0]  addr;
      logic [15:0] exp;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   function automatic logic [2:0] pat0(int r, int c);
      return (c == r + 3) ? 3'b111 : 3'(r);
   endfunction

   function automatic logic [2:0] pat1(int r, int c);
      return (c == 31 - r) ? 3'b000 : ~3'(r);
   endfunction

   task automatic chk(input string nm,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%h want 0x%h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift(input logic [2:0] d0,
                        input logic [2:0] d1);
      rgb0 = d0;
      rgb1 = d1;
      rgb_clk = 1'b1;
      @(negedge clk);
      rgb_clk = 1'b0;
      @(negedge clk);
   endtask

   task automatic strobe(input logic [2:0] l);
      {rgb_c, rgb_b, rgb_a} = l;
      rgb_stb = 1'b1;
      t_raise = cyc;
      @(negedge clk);
      rgb_stb = 1'b0;
      idle(5);
   endtask

   task automatic rd(input logic [9:0] a,
                     output logic [15:0] d);
      address = a;
      @(negedge clk);
      d = data_out;
   endtask

   task automatic rchk(input string nm,
                       input logic [9:0] a,
                       input logic [15:0] exp);
      logic [15:0] d;
      rd(a, d);
      chk(nm, d, exp);
   endtask

   task automatic clrp();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      idle(2);
   endtask

   initial begin
      logic [15:0] d;
      logic [15:0] e;
      logic [9:0]  a;

      tbl[0]  = '{10'h200, 16'h0000};
      tbl[1]  = '{10'h201, 16'h0001};
      tbl[2]  = '{10'h202, 16'h0008};
      tbl[3]  = '{10'h203, 16'h0007};
      tbl[4]  = '{10'h000, 16'h0000};
      tbl[5]  = '{10'h003, 16'h0007};
      tbl[6]  = '{10'h0A8, 16'h0007};
      tbl[7]  = '{10'h0A9, 16'h0005};
      tbl[8]  = '{10'h0DF, 16'h0006};
      tbl[9]  = '{10'h120, 16'h0006};
      tbl[10] = '{10'h1FF, 16'h0000};
      tbl[11] = '{10'h191, 16'h0003};
      tbl[12] = '{10'h15D, 16'h0000};
      tbl[13] = '{10'h15C, 16'h0005};

      // reset state
      idle(3);
      chk("rst_dout", data_out, 16'h0);
      chk("rst_fstb", 16'(frame_stb), 16'h0);
      chk("rst_err", 16'(err), 16'h0);
      rst_n = 1'b1;
      idle(2);
      rchk("rst_stat", 10'h200, 16'h0000);
      rchk("rst_cnt", 10'h203, 16'h0000);
      rchk("rst_pix", 10'h0E0, 16'h0000);

      // single row, lines 6 -> row 7
      for (int c = 0; c < 32; c++) begin
         shift((c == 0) ? 3'b100 : 3'b000, 3'b011);
      end
      strobe(3'd6);
      chk("t1_lat", 16'(stb_cyc - t_raise), 16'd3);
      chk("t1_nstb", 16'(nstb), 16'd1);
      rchk("t1_p0", 10'h0E0, 16'h0004);
      rchk("t1_p1", 10'h0E1, 16'h0000);
      rchk("t1_p2", 10'h1E5, 16'h0003);
      rchk("t1_fcnt", 10'h201, 16'h0001);
      rchk("t1_lcnt", 10'h202, 16'h0001);
      rchk("t1_crow", 10'h203, 16'h0007);

      // full frame, lines 7,0..6 -> rows 0..7
      clrp();
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 32; c++) begin
            shift(pat0(r, c), pat1(r, c));
         end
         strobe(3'(r + 7));
      end
      chk("ff_nstb", 16'(nstb), 16'd2);
      chk("ff_err", 16'(err), 16'h0);
      for (int i = 0; i < NV; i++) begin
         rd(tbl[i].addr, d);
         chk($sformatf("tbl%0d", i), d, tbl[i].exp);
      end
      for (int h = 0; h < 2; h++) begin
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
               a = {1'b0, 1'(h), 3'(r), 5'(c)};
               e = {13'b0, (h == 1) ? pat1(r, c) : pat0(r, c)};
               rd(a, d);
               chk($sformatf("ff_h%0d_r%0d_c%0d", h, r, c), d, e);
            end
         end
      end

      // overflow: 33 pulses
      for (int k = 0; k < 33; k++) begin
         shift(3'(k + 1), 3'(k));
      end
      rchk("ovf_ccnt", 10'h203, 16'h0107);
      strobe(3'd3);
      rchk("ovf_stat", 10'h200, 16'h0001);
      rchk("ovf_crow", 10'h203, 16'h0004);
      rchk("ovf_c0", 10'h080, 16'h0001);
      rchk("ovf_c5", 10'h085, 16'h0006);
      rchk("ovf_c31", 10'h09F, 16'h0000);
      rchk("ovf_h1c31", 10'h19F, 16'h0007);
      chk("ovf_err", 16'(err), 16'h1);

      // underflow: 31 pulses
      clrp();
      for (int k = 0; k < 31; k++) begin
         shift(3'b101, 3'b010);
      end
      strobe(3'd0);
      rchk("unf_stat", 10'h200, 16'h0002);
      rchk("unf_crow", 10'h203, 16'h0001);
      rchk("unf_c0", 10'h120, 16'h0002);
      rchk("unf_keep", 10'h13F, 16'h0007);
      chk("unf_err", 16'(err), 16'h1);
      clrp();
      rchk("clr_stat", 10'h200, 16'h0000);
      chk("clr_err", 16'(err), 16'h0);

      // 32nd shift and strobe in the same cycle
      for (int k = 0; k < 31; k++) begin
         shift(3'b001, 3'b000);
      end
      {rgb_c, rgb_b, rgb_a} = 3'd2;
      rgb0 = 3'b110;
      rgb1 = 3'b111;
      rgb_clk = 1'b1;
      rgb_stb = 1'b1;
      @(negedge clk);
      rgb_clk = 1'b0;
      rgb_stb = 1'b0;
      idle(5);
      rchk("sim_stat", 10'h200, 16'h0000);
      rchk("sim_c31", 10'h07F, 16'h0006);
      rchk("sim_c0", 10'h060, 16'h0001);
      rchk("sim_h1c31", 10'h17F, 16'h0007);
      rchk("sim_crow", 10'h203, 16'h0003);
      chk("sim_err", 16'(err), 16'h0);

      // clr coincident with a short latch
      for (int k = 0; k < 4; k++) begin
         shift(3'b111, 3'b000);
      end
      {rgb_c, rgb_b, rgb_a} = 3'd5;
      rgb_stb = 1'b1;
      @(negedge clk);
      rgb_stb = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      idle(4);
      rchk("cc_lcnt", 10'h202, 16'h0000);
      rchk("cc_stat", 10'h200, 16'h0000);
      rchk("cc_c0", 10'h0C0, 16'h0007);
      rchk("cc_c4", 10'h0C4, 16'h0001);
      rchk("cc_crow", 10'h203, 16'h0006);
      chk("cc_nstb", 16'(nstb), 16'd2);

      // reset mid-row
      for (int k = 0; k < 10; k++) begin
         shift(3'b111, 3'b000);
      end
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(2);
      rchk("mr_img", 10'h07F, 16'h0000);
      rchk("mr_fcnt", 10'h201, 16'h0000);
      rchk("mr_lcnt", 10'h202, 16'h0000);
      idle(40);
      for (int k = 0; k < 5; k++) begin
         shift(3'b010, 3'b000);
      end
      strobe(3'd4);
      rchk("mr_stat", 10'h200, 16'h0002);
      rchk("mr_c0", 10'h0A0, 16'h0002);
      rchk("mr_c5", 10'h0A5, 16'h0000);

`ifdef LED_MATRIX_RX_BLANK_CHECK_EN
      // blank too short before strobe
      idle(40);
      clrp();
      oe_n = 1'b0;
      idle(4);
      oe_n = 1'b1;
      idle(16);
      strobe(3'd0);
      rd(10'h200, d);
      chk("bl_pre16", d & 16'h4, 16'h4);

      // exactly 0x20 before and after
      idle(40);
      clrp();
      oe_n = 1'b0;
      idle(4);
      oe_n = 1'b1;
      idle(32);
      rgb_stb = 1'b1;
      @(negedge clk);
      rgb_stb = 1'b0;
      idle(31);
      oe_n = 1'b0;
      idle(4);
      oe_n = 1'b1;
      idle(4);
      rd(10'h200, d);
      chk("bl_exact", d & 16'h4, 16'h0);

      // blank too short after strobe
      idle(40);
      clrp();
      oe_n = 1'b0;
      idle(4);
      oe_n = 1'b1;
      idle(32);
      rgb_stb = 1'b1;
      @(negedge clk);
      rgb_stb = 1'b0;
      idle(15);
      oe_n = 1'b0;
      idle(4);
      oe_n = 1'b1;
      idle(4);
      rd(10'h200, d);
      chk("bl_post16", d & 16'h4, 16'h4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
